// File: rtl/sweep_if.sv
// Command/status bundle between a sweep job source and sweep_sequencer,
// plus the control/feedback lines of the up/down counter datapath.
//   master: job source (command, pause/abort) and counter (cnt_q) side
//   slave : sweep_sequencer
//   cmd_valid/cmd_ready/cmd_lo/cmd_hi/cmd_sweeps : job request handshake
//   pause/abort                                  : run control
//   cnt_q -> cnt_clr/cnt_en/cnt_mode             : counter datapath
//   busy/dir/half_cnt/done/err                   : job status
interface sweep_if #(
    parameter int W       = 8,
    parameter int SWEEP_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [W-1:0]       cmd_lo;
    logic [W-1:0]       cmd_hi;
    logic [SWEEP_W-1:0] cmd_sweeps;
    logic               pause;
    logic               abort;
    logic [W-1:0]       cnt_q;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_mode;
    logic               busy;
    logic               dir;
    logic [SWEEP_W-1:0] half_cnt;
    logic               done;
    logic               err;

    modport master (
        output cmd_valid, cmd_lo, cmd_hi, cmd_sweeps, pause, abort, cnt_q,
        input  cmd_ready, cnt_clr, cnt_en, cnt_mode, busy, dir, half_cnt, done, err
    );

    modport slave (
        input  cmd_valid, cmd_lo, cmd_hi, cmd_sweeps, pause, abort, cnt_q,
        output cmd_ready, cnt_clr, cnt_en, cnt_mode, busy, dir, half_cnt, done, err
    );
endinterface

// File: rtl/sweep_sequencer.sv
// Sweep sequencer: drives an enable-gated up/down counter through
// clear -> seek to lo -> lo..hi..lo half-sweeps, with pause and abort.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : sweep_if.slave (command, run control, counter control, status)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready high
// CLEAR  | one cycle clearing the counter to 0
// SEEK   | stepping up from 0 until the counter reaches lo
// UP     | stepping up toward hi; dwell one cycle at hi, then turn
// DOWN   | stepping down toward lo; dwell one cycle at lo, then turn
// DONE   | one-cycle done pulse, counter left at the final endpoint
module sweep_sequencer #(
    parameter int W       = 8,
    parameter int MAX_VAL = 29,
    parameter int SWEEP_W = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    sweep_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SEEK, S_UP, S_DOWN, S_DONE
    } state_t;

    localparam logic [W-1:0] LP_MAX = W'(MAX_VAL);

    state_t             r_state;
    logic [W-1:0]       r_lo;
    logic [W-1:0]       r_hi;
    logic [SWEEP_W-1:0] r_sweeps;
    logic [SWEEP_W-1:0] r_half_cnt;
    logic               r_dir;
    logic               r_done;
    logic               r_err;

    state_t             w_state_nxt;
    logic               w_dir_nxt;
    logic               w_clr;
    logic               w_en;
    logic               w_mode;
    logic               w_accept;
    logic               w_reject;
    logic               w_turn;
    logic               w_cmd_bad;
    logic [SWEEP_W-1:0] w_half_inc;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_mode      = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_turn      = 1'b0;
        w_half_inc  = r_half_cnt + SWEEP_W'(1);
        w_cmd_bad   = (bus.cmd_lo >= bus.cmd_hi) || (bus.cmd_hi > LP_MAX) ||
                      (bus.cmd_sweeps == '0);

        // Abort outranks pause and turnaround; the clear leaves the counter at 0.
        if (r_state != S_IDLE && bus.abort) begin
            w_clr       = 1'b1;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (w_cmd_bad) begin
                            w_reject = 1'b1;
                        end else begin
                            w_accept    = 1'b1;
                            w_dir_nxt   = 1'b0;
                            w_state_nxt = S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    w_clr       = 1'b1;
                    w_state_nxt = S_SEEK;
                end
                S_SEEK: begin
                    if (!bus.pause) begin
                        if (bus.cnt_q != r_lo) begin
                            w_en = 1'b1;
                        end else begin
                            w_dir_nxt   = 1'b0;
                            w_state_nxt = S_UP;
                        end
                    end
                end
                S_UP: begin
                    if (!bus.pause) begin
                        if (bus.cnt_q != r_hi) begin
                            w_en = 1'b1;
                        end else begin
                            // Endpoint reached: this cycle is the dwell, no step.
                            w_turn = 1'b1;
                            if (w_half_inc == r_sweeps) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_dir_nxt   = 1'b1;
                                w_state_nxt = S_DOWN;
                            end
                        end
                    end
                end
                S_DOWN: begin
                    if (!bus.pause) begin
                        if (bus.cnt_q != r_lo) begin
                            w_en   = 1'b1;
                            w_mode = 1'b1;
                        end else begin
                            w_turn = 1'b1;
                            if (w_half_inc == r_sweeps) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_dir_nxt   = 1'b0;
                                w_state_nxt = S_UP;
                            end
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_lo       <= '0;
            r_hi       <= '0;
            r_sweeps   <= '0;
            r_half_cnt <= '0;
            r_dir      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= (w_state_nxt == S_DONE);
            r_err   <= w_reject;
            if (w_accept) begin
                r_lo       <= bus.cmd_lo;
                r_hi       <= bus.cmd_hi;
                r_sweeps   <= bus.cmd_sweeps;
                r_half_cnt <= '0;
            end else if (w_turn) begin
                r_half_cnt <= w_half_inc;
            end
        end
    end

    assign bus.cnt_clr   = w_clr;
    assign bus.cnt_en    = w_en;
    assign bus.cnt_mode  = w_mode;
    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.dir       = r_dir;
    assign bus.half_cnt  = r_half_cnt;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: an up/down counter model closes the loop and a
// reference list of expected counter values per cycle is built from the
// sweep rules (seek 0..lo, then alternating lo..hi / hi..lo runs).
module tb_sweep_sequencer;
    localparam int W    = 8;
    localparam int SW   = 8;
    localparam int MAXV = 29;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] q = '0;
    int total = 0;
    int bad   = 0;

    sweep_if #(.W(W), .SWEEP_W(SW)) bus ();

    sweep_sequencer #(.W(W), .MAX_VAL(MAXV), .SWEEP_W(SW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Counter datapath model: clr wins, else step by mode, else hold.
    always @(posedge clk) begin
        if (bus.cnt_clr)     q <= '0;
        else if (bus.cnt_en) q <= bus.cnt_mode ? q - 1'b1 : q + 1'b1;
    end
    assign bus.cnt_q = q;

    task automatic start_cmd(input int lo, input int hi, input int sw);
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_lo     = W'(lo);
        bus.cmd_hi     = W'(hi);
        bus.cmd_sweeps = SW'(sw);
        @(negedge clk);
        bus.cmd_valid  = 1'b0;
    endtask

    // pmode: 0 no pause, 1 random pause, 2 pause 3 cycles at q=3 in the
    // first up run and 2 cycles at the first hi dwell.
    task automatic run_job(input int lo, input int hi, input int sw, input int pmode);
        int exp_q[$];
        int exp_h[$];
        int exp_d[$];
        int j, n, guard, hold, p;
        bit used3, usedhi;
        for (int v = 0; v <= lo; v++) begin
            exp_q.push_back(v); exp_h.push_back(0); exp_d.push_back(0);
        end
        for (int k = 0; k < sw; k++) begin
            for (int s = 0; s <= hi - lo; s++) begin
                exp_q.push_back((k % 2 == 0) ? lo + s : hi - s);
                exp_h.push_back(k);
                exp_d.push_back(k % 2);
            end
        end
        exp_q.push_back((sw % 2 == 1) ? hi : lo);
        exp_h.push_back(sw);
        exp_d.push_back((sw - 1) % 2);
        n = exp_q.size();

        start_cmd(lo, hi, sw);
        total++;
        if (bus.busy !== 1'b1 || bus.cnt_clr !== 1'b1 || bus.cnt_en !== 1'b0) begin
            bad++;
            $display("FAIL clear_cycle lo=%0d hi=%0d: busy=%b clr=%b en=%b, want 1 1 0",
                     lo, hi, bus.busy, bus.cnt_clr, bus.cnt_en);
        end
        bus.pause = (pmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);

        j = 0; guard = 0; hold = 0; used3 = 0; usedhi = 0;
        while (j < n && guard < 2000) begin
            guard++;
            total++;
            if (int'(q) !== exp_q[j]) begin
                bad++;
                $display("FAIL cnt_q lo=%0d hi=%0d sw=%0d step=%0d: got %0d want %0d",
                         lo, hi, sw, j, q, exp_q[j]);
            end
            total++;
            if (int'(bus.half_cnt) !== exp_h[j] || int'(bus.dir) !== exp_d[j]) begin
                bad++;
                $display("FAIL half_dir step=%0d: got half=%0d dir=%b want half=%0d dir=%0d",
                         j, bus.half_cnt, bus.dir, exp_h[j], exp_d[j]);
            end
            total++;
            if (bus.done !== (j == n - 1) || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL done_busy step=%0d: got done=%b busy=%b want done=%0d busy=1",
                         j, bus.done, bus.busy, (j == n - 1));
            end
            p = 0;
            if (pmode == 1) begin
                p = ($urandom_range(0, 3) == 0) ? 1 : 0;
            end else if (pmode == 2) begin
                if (hold == 0 && !used3 && j == 4)      begin hold = 3; used3  = 1; end
                if (hold == 0 && !usedhi && j == hi + 1) begin hold = 2; usedhi = 1; end
                if (hold > 0) begin p = 1; hold--; end
            end
            bus.pause = 1'(p);
            #1;
            total++;
            if (bus.cnt_en === 1'b1 && (bus.cnt_clr === 1'b1 || (p == 1 && j < n - 1))) begin
                bad++;
                $display("FAIL en_gate step=%0d: en=%b clr=%b pause=%0d, want en=0",
                         j, bus.cnt_en, bus.cnt_clr, p);
            end
            if (!(p == 1 && j < n - 1)) j++;
            @(negedge clk);
        end
        bus.pause = 1'b0;
        total++;
        if (guard >= 2000) begin
            bad++;
            $display("FAIL job_timeout lo=%0d hi=%0d sw=%0d: stuck at step %0d of %0d", lo, hi, sw, j, n);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 ||
            int'(q) !== exp_q[n-1]) begin
            bad++;
            $display("FAIL job_end: busy=%b done=%b ready=%b q=%0d want 0 0 1 q=%0d",
                     bus.busy, bus.done, bus.cmd_ready, q, exp_q[n-1]);
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.err !== 1'b0 || bus.half_cnt !== '0 || bus.dir !== 1'b0 ||
            bus.cnt_clr !== 1'b0 || bus.cnt_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b err=%b half=%0d dir=%b clr=%b en=%b",
                     bus.cmd_ready, bus.busy, bus.done, bus.err, bus.half_cnt, bus.dir,
                     bus.cnt_clr, bus.cnt_en);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_job(2, 5, 2, 0);
        run_job(0, 29, 1, 0);
        run_job(3, 7, 3, 0);
    endtask

    task automatic test_errors();
        int tbl[4][3] = '{'{4, 4, 1}, '{2, 5, 0}, '{0, 30, 1}, '{6, 3, 2}};
        for (int i = 0; i < 4; i++) begin
            start_cmd(tbl[i][0], tbl[i][1], tbl[i][2]);
            total++;
            if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 ||
                bus.cnt_clr !== 1'b0) begin
                bad++;
                $display("FAIL reject_%0d: err=%b busy=%b ready=%b clr=%b want 1 0 1 0",
                         i, bus.err, bus.busy, bus.cmd_ready, bus.cnt_clr);
            end
            @(negedge clk);
            total++;
            if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL reject_pulse_%0d: err=%b busy=%b want 0 0", i, bus.err, bus.busy);
            end
        end
        run_job(1, 4, 1, 0);
    endtask

    task automatic test_pause();
        run_job(1, 6, 2, 2);
    endtask

    task automatic test_random();
        int lo, hi, sw;
        for (int i = 0; i < 6; i++) begin
            lo = $urandom_range(0, 20);
            hi = $urandom_range(lo + 1, MAXV);
            sw = $urandom_range(1, 4);
            run_job(lo, hi, sw, 1);
        end
    endtask

    task automatic test_abort();
        int guard;
        start_cmd(2, 9, 4);
        guard = 0;
        while (!(bus.dir === 1'b1 && q == 7) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 100) begin
            bad++;
            $display("FAIL abort_reach: never saw DOWN at q=7, q=%0d dir=%b", q, bus.dir);
        end
        bus.pause = 1'b1;
        bus.abort = 1'b1;
        #1;
        total++;
        if (bus.cnt_clr !== 1'b1 || bus.cnt_en !== 1'b0) begin
            bad++;
            $display("FAIL abort_clr: clr=%b en=%b want 1 0", bus.cnt_clr, bus.cnt_en);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        bus.pause = 1'b0;
        total++;
        if (q !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.half_cnt !== SW'(1)) begin
            bad++;
            $display("FAIL abort_after: q=%0d busy=%b done=%b half=%0d want 0 0 0 1",
                     q, bus.busy, bus.done, bus.half_cnt);
        end
        bus.abort = 1'b1;
        #1;
        total++;
        if (bus.cnt_clr !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: clr=%b busy=%b want 0 0", bus.cnt_clr, bus.busy);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        run_job(3, 8, 2, 0);
    endtask

    task automatic test_reset_mid_up();
        int guard;
        start_cmd(2, 5, 3);
        guard = 0;
        while (!(bus.dir === 1'b0 && q == 3 && bus.half_cnt == SW'(2)) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 100) begin
            bad++;
            $display("FAIL reset_reach: never saw UP at q=3 half=2, q=%0d half=%0d", q, bus.half_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.half_cnt !== '0 ||
            bus.cnt_en !== 1'b0 || bus.cnt_clr !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: ready=%b busy=%b half=%0d en=%b clr=%b done=%b",
                     bus.cmd_ready, bus.busy, bus.half_cnt, bus.cnt_en, bus.cnt_clr, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        run_job(2, 5, 1, 0);
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_lo     = '0;
        bus.cmd_hi     = '0;
        bus.cmd_sweeps = '0;
        bus.pause      = 1'b0;
        bus.abort      = 1'b0;
        test_reset();
        test_directed();
        test_errors();
        test_pause();
        test_random();
        test_abort();
        test_reset_mid_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
